cpu_datapath: RTL
=================

Name: cpu_datapath

Overview:
Sequential datapath for the 3-bit-opcode accumulator CPU. It is the consumer of the instruction controller's nine control strobes and the producer of the controller's inputs (phase, opcode, zero). It holds the phase counter, instruction register, program counter and accumulator, plus the ALU, the address mux and the memory-port drive. It sits between the controller and the single-port program/data memory.

Parameters:
ADDR_WIDTH, 5, program counter and operand address width; the instruction word is {opcode[2:0], addr[ADDR_WIDTH-1:0]}.
DATA_WIDTH, 8, accumulator and memory data width; must equal 3+ADDR_WIDTH.

Ports:
clk  input  1  rising-edge clock, the single clock domain.
rst_n  input  1  asynchronous, active-low reset.
sel  input  1  address select: 1 = pc, 0 = ir operand address.
rd  input  1  memory read strobe from the controller.
ld_ir  input  1  load instruction register from mem_rdata.
halt  input  1  halt request.
inc_pc  input  1  increment program counter.
ld_ac  input  1  load accumulator from ALU result.
wr  input  1  memory write strobe.
ld_pc  input  1  load pc from ir operand address.
data_e  input  1  drive accumulator onto the write-data bus.
mem_rdata  input  DATA_WIDTH  memory read data.
phase  output  3  current phase, 0..7.
opcode  output  3  ir[DATA_WIDTH-1:DATA_WIDTH-3].
zero  output  1  combinational; 1 when acc == 0.
mem_addr  output  ADDR_WIDTH  sel ? pc : ir[ADDR_WIDTH-1:0].
mem_wdata  output  DATA_WIDTH  acc when data_e is 1; 0 otherwise.
mem_we  output  1  equals wr.
mem_re  output  1  equals rd.
halted  output  1  sticky halt status.
pc  output  ADDR_WIDTH  program counter, for observation.
acc  output  DATA_WIDTH  accumulator, for observation.

Behaviour:
- Reset (rst_n low, asynchronous): phase=0, ir=0 (opcode=HLT), pc=0, acc=0, halted=0.
  - Consequences: zero=1, mem_addr=0, mem_wdata=0.
  - Reset mid-instruction aborts it immediately; the first edge after release is phase 0.
- Opcode encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- Phase counter:
  - Increments by 1 every clock and wraps 7->0.
  - Frozen while halted=1.
- Halt:
  - halted is set on an edge where halt=1 and halted=0. That edge's phase advance still occurs: HLT decoded at phase 4 freezes at phase 5.
  - halted clears only on reset.
  - While halted, ir, pc and acc also hold and all load strobes are ignored.
- Instruction register: loads mem_rdata on any edge with ld_ir=1. It is asserted in phases 2 and 3, so the same word loads twice, which is harmless.
- Program counter, priority ld_pc > inc_pc:
  - ld_pc=1: pc <= ir[ADDR_WIDTH-1:0].
  - else inc_pc=1: pc <= pc+1, modulo 2^ADDR_WIDTH (wrap 31->0 at the default width).
- Accumulator: loads the ALU result on an edge with ld_ac=1.
- ALU, with b = mem_rdata:
  - ADD: acc+b, truncated to DATA_WIDTH; carry discarded.
  - AND: acc&b.
  - XOR: acc^b.
  - LDA: b.
  - Any other opcode: acc unchanged.
- zero is evaluated on the current acc (pre-load), so SKZ tests the accumulator from before the instruction.
- Latency: an instruction fetched at phases 0-3 completes its acc or pc update on the phase-7 edge. A SKZ skip takes effect on the phase-6 edge. There is one instruction every 8 clocks.
- Simultaneous events:
  - ld_ac with wr: acc updates, and memory sees the old acc on the same edge.
  - halt with any load: halt wins for all subsequent cycles; the coincident-edge loads still take effect.

Test Plan:
1. Reset release with memory[0]=8'hA3 (LDA 3), memory[3]=8'h5C -> phases 0..7 cycle; ir=8'hA3 after phase 3; pc=1 after phase 4; acc=8'h5C after phase 7; zero=0.
2. acc=8'hF0, ADD of operand 8'h25 -> acc=8'h15 (carry dropped). Then XOR of 8'h15 -> acc=0 and zero=1.
3. acc=0, SKZ at pc=4 -> pc=5 after phase 4 and pc=6 after phase 6. Repeat with acc=1 -> pc stays at 5.
4. JMP 8'hFE (addr 30) with inc_pc and ld_pc both asserted on one edge -> pc=30. Then a sequential run from pc=31 -> pc wraps to 0.
5. STO 9 with acc=8'h77 -> mem_addr=9 in phases 4-7; mem_wdata=8'h77 in phases 6-7; mem_we=1 only in phase 7.
6. HLT at phase 4 -> halted=1; phase stuck at 5 for 20 clocks; pc and acc unchanged. Then rst_n low for one cycle -> all state at reset values and execution restarts from pc=0.

Source files
------------

// File: rtl/cpu_datapath_if.sv
// Memory port bundle between the accumulator datapath and the
// single-port program/data memory.
interface cpu_datapath_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_we;
   logic                  mem_re;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_we,
      output mem_re,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_we,
      input  mem_re,
      output mem_rdata
   );
endinterface

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: phase counter, ir, pc, acc, ALU and memory-port drive.
// Consumes the controller's strobes and returns phase/opcode/zero to it.
module cpu_datapath #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sel,
   input  logic                  rd,
   input  logic                  ld_ir,
   input  logic                  halt,
   input  logic                  inc_pc,
   input  logic                  ld_ac,
   input  logic                  wr,
   input  logic                  ld_pc,
   input  logic                  data_e,
   output logic [2:0]            phase,
   output logic [2:0]            opcode,
   output logic                  zero,
   output logic                  halted,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [DATA_WIDTH-1:0] acc,
   cpu_datapath_if.master        mem
);

   typedef enum logic [2:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STO = 3'd6,
      OP_JMP = 3'd7
   } op_e;

   localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [2:0]            phase_q, phase_d;
   logic [DATA_WIDTH-1:0] ir_q, ir_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic                  halted_q, halted_d;
   logic [DATA_WIDTH-1:0] alu_out;
   op_e                   op;

   assign op = op_e'(ir_q[DATA_WIDTH-1 -: 3]);

   always_comb begin
      alu_out = acc_q;
      case (op)
         OP_ADD:  alu_out = acc_q + mem.mem_rdata;
         OP_AND:  alu_out = acc_q & mem.mem_rdata;
         OP_XOR:  alu_out = acc_q ^ mem.mem_rdata;
         OP_LDA:  alu_out = mem.mem_rdata;
         default: alu_out = acc_q;
      endcase
   end

   // The halting edge itself still advances phase and applies its loads.
   always_comb begin
      phase_d  = phase_q;
      ir_d     = ir_q;
      pc_d     = pc_q;
      acc_d    = acc_q;
      halted_d = halted_q;
      if (!halted_q) begin
         phase_d = phase_q + 3'd1;
         if (ld_ir) ir_d = mem.mem_rdata;
         if (ld_pc) begin
            pc_d = ir_q[ADDR_WIDTH-1:0];
         end else if (inc_pc) begin
            pc_d = pc_q + PC_ONE;
         end
         if (ld_ac) acc_d = alu_out;
         if (halt)  halted_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= '0;
         ir_q     <= '0;
         pc_q     <= '0;
         acc_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         ir_q     <= ir_d;
         pc_q     <= pc_d;
         acc_q    <= acc_d;
         halted_q <= halted_d;
      end
   end

   assign phase     = phase_q;
   assign opcode    = ir_q[DATA_WIDTH-1 -: 3];
   assign zero      = (acc_q == '0);
   assign halted    = halted_q;
   assign pc        = pc_q;
   assign acc       = acc_q;

   assign mem.mem_addr  = sel ? pc_q : ir_q[ADDR_WIDTH-1:0];
   assign mem.mem_wdata = data_e ? acc_q : '0;
   assign mem.mem_we    = wr;
   assign mem.mem_re    = rd;

endmodule
